mem_wr_lb_arbiter: RTL and testbench



---
 rtl/mem_wr_lb_arbiter_if.sv | 40 ++++
 rtl/mem_wr_lb_arbiter.sv | 164 ++++++++++++++++
 tb/tb_mem_wr_lb_arbiter.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_wr_lb_arbiter_if.sv
`default_nettype none
// ============================================================================
// mem_wr_lb_arbiter_if : requester-side and write-path-side signal bundle
//                        for mem_wr_lb_arbiter.   Rev 1.0
// ============================================================================
interface mem_wr_lb_arbiter_if #(
  parameter int P_PORTS = 4,
  parameter int P_IDW   = 3
);
  logic [P_PORTS-1:0]     UP_REQ;
  logic [32*P_PORTS-1:0]  UP_ADR;
  logic [20*P_PORTS-1:0]  UP_LEN;
  logic [P_PORTS-1:0]     UP_ACK;
  logic [P_PORTS-1:0]     UP_RRDY;
  logic [P_PORTS-1:0]     UP_RDEN;
  logic [256*P_PORTS-1:0] UP_RDAT;
  logic                   SYS_LB_REQ;
  logic [31:0]            SYS_LB_ADR;
  logic [19:0]            SYS_LB_LEN;
  logic                   SYS_LB_ACK;
  logic                   SYS_LB_RRDY;
  logic                   SYS_LB_RDEN;
  logic [255:0]           SYS_LB_RDAT;
  logic [P_IDW-1:0]       GNT_IDX;
  logic                   BUSY;

  // The arbiter drives the shared write-path bus, hence it is the master.
  modport master (
    input  UP_REQ, UP_ADR, UP_LEN, UP_RRDY, UP_RDAT, SYS_LB_ACK, SYS_LB_RDEN,
    output UP_ACK, UP_RDEN, SYS_LB_REQ, SYS_LB_ADR, SYS_LB_LEN, SYS_LB_RRDY,
           SYS_LB_RDAT, GNT_IDX, BUSY
  );

  modport slave (
    output UP_REQ, UP_ADR, UP_LEN, UP_RRDY, UP_RDAT, SYS_LB_ACK, SYS_LB_RDEN,
    input  UP_ACK, UP_RDEN, SYS_LB_REQ, SYS_LB_ADR, SYS_LB_LEN, SYS_LB_RRDY,
           SYS_LB_RDAT, GNT_IDX, BUSY
  );
endinterface
`default_nettype wire

// File: rtl/mem_wr_lb_arbiter.sv
`default_nettype none
// ============================================================================
// mem_wr_lb_arbiter : round-robin share of one 256b write-request bus among
//                     P_PORTS requesters; MEM_WR_ARB_PRIO_EN = port 0 strict
//                     priority.   Rev 1.0
// ============================================================================
module mem_wr_lb_arbiter #(
  parameter int P_PORTS = 4,
  parameter int P_IDW   = 3
) (
  input  wire logic           CLK,
  input  wire logic           RST,
  mem_wr_lb_arbiter_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARB   = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [P_IDW-1:0]   gnt_q, gnt_d;
  logic [P_IDW-1:0]   ptr_q, ptr_d;
  logic [31:0]        adr_q, adr_d;
  logic [19:0]        len_q, len_d;

  logic [P_PORTS-1:0] arb_req;
  logic [P_IDW-1:0]   pick, hi_pick;
  logic               pick_vld, hi_vld;
  logic [31:0]        adr_mux;
  logic [19:0]        len_mux;
  logic               ptr_adv;
  logic               busy_data;
  logic [255:0]       rdat_mux;
  logic               rrdy_mux;
  logic [P_PORTS-1:0] rden_vec, ack_vec;

`ifdef MEM_WR_ARB_PRIO_EN
  // Port 0 is taken out of the rotation and overrides it in the picker.
  assign arb_req = bus.UP_REQ & ~P_PORTS'(1);
  assign ptr_adv = (gnt_q != '0);
`else
  assign arb_req = bus.UP_REQ;
  assign ptr_adv = 1'b1;
`endif

  // Lowest request at or above the pointer wins; otherwise lowest overall (wrap).
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    hi_pick  = '0;
    hi_vld   = 1'b0;
    for (int i = P_PORTS - 1; i >= 0; i--) begin
      if (arb_req[i]) begin
        pick     = P_IDW'(i);
        pick_vld = 1'b1;
        if (P_IDW'(i) >= ptr_q) begin
          hi_pick = P_IDW'(i);
          hi_vld  = 1'b1;
        end
      end
    end
    if (hi_vld) pick = hi_pick;
`ifdef MEM_WR_ARB_PRIO_EN
    if (bus.UP_REQ[0]) begin
      pick     = '0;
      pick_vld = 1'b1;
    end
`endif
  end

  always_comb begin
    adr_mux = '0;
    len_mux = '0;
    for (int n = 0; n < P_PORTS; n++) begin
      if (pick == P_IDW'(n)) begin
        adr_mux = bus.UP_ADR[32*n +: 32];
        len_mux = bus.UP_LEN[20*n +: 20];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    adr_d   = adr_q;
    len_d   = len_q;
    case (state_q)
      S_IDLE: begin
        if (|bus.UP_REQ) state_d = S_ARB;
      end
      S_ARB: begin
        if (pick_vld) begin
          gnt_d   = pick;
          adr_d   = adr_mux;
          len_d   = len_mux;
          state_d = (len_mux == '0) ? S_DONE : S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (bus.SYS_LB_ACK) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (ptr_adv) ptr_d = (gnt_q == P_IDW'(P_PORTS - 1)) ? '0 : gnt_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
      adr_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      adr_q   <= adr_d;
      len_q   <= len_d;
    end
  end

  // Data handshake only reaches a requester while its transfer is in flight.
  assign busy_data = (state_q == S_WAIT);

  always_comb begin
    rdat_mux = '0;
    rrdy_mux = 1'b0;
    rden_vec = '0;
    ack_vec  = '0;
    for (int n = 0; n < P_PORTS; n++) begin
      if (gnt_q == P_IDW'(n)) begin
        rdat_mux    = bus.UP_RDAT[256*n +: 256];
        rrdy_mux    = bus.UP_RRDY[n];
        rden_vec[n] = bus.SYS_LB_RDEN & busy_data;
        ack_vec[n]  = (state_q == S_DONE);
      end
    end
  end

  assign bus.SYS_LB_REQ  = (state_q == S_ISSUE);
  assign bus.SYS_LB_ADR  = adr_q;
  assign bus.SYS_LB_LEN  = len_q;
  assign bus.SYS_LB_RRDY = rrdy_mux & busy_data;
  assign bus.SYS_LB_RDAT = rdat_mux;
  assign bus.UP_RDEN     = rden_vec;
  assign bus.UP_ACK      = ack_vec;
  assign bus.GNT_IDX     = gnt_q;
  assign bus.BUSY        = (state_q == S_ISSUE) || (state_q == S_WAIT) ||
                           (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_mem_wr_lb_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_wr_lb_arbiter : directed bench with a small write-path / requester
//                        model around mem_wr_lb_arbiter.   Rev 1.0
// ============================================================================
module tb_mem_wr_lb_arbiter;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  mem_wr_lb_arbiter_if #(.P_PORTS(4), .P_IDW(3)) bus ();

  mem_wr_lb_arbiter #(.P_PORTS(4), .P_IDW(3)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int rden_cnt[4];
  int ack_cnt[4];
  int up_ack_cyc[4];
  int req_pulses, outstanding, overlap, rdat_bad;
  int wp_len, wp_cnt, wp_ack_cyc;
  bit wp_active, inj_ack, force_rden;
  logic [3:0] drop_pend, hold_req;
  int gnt_log[$];
  logic [31:0] adr_log[$];
  int exp6[4];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] pat(input int n);
    return {8{32'hA5A5_0000 | 32'(n)}};
  endfunction

  task automatic clr();
    for (int n = 0; n < 4; n++) begin
      rden_cnt[n] = 0; ack_cnt[n] = 0; up_ack_cyc[n] = 0;
    end
    req_pulses = 0; outstanding = 0; overlap = 0; rdat_bad = 0;
    wp_ack_cyc = 0;
    gnt_log.delete();
    adr_log.delete();
  endtask

  task automatic set_port(input int n, input logic [31:0] adr, input logic [19:0] len);
    bus.UP_ADR[32*n +: 32] = adr;
    bus.UP_LEN[20*n +: 20] = len;
  endtask

  // One clock: observe registered outputs, run requester/write-path model,
  // then observe the combinational data-path outputs.
  task automatic cycle();
    @(posedge CLK);
    #1;
    cyc++;
    bus.UP_REQ = bus.UP_REQ & ~drop_pend;
    drop_pend  = '0;
    if (bus.SYS_LB_REQ) begin
      req_pulses++;
      gnt_log.push_back(int'(bus.GNT_IDX));
      adr_log.push_back(bus.SYS_LB_ADR);
      if (outstanding != 0) overlap++;
      outstanding = 1;
      wp_len = int'(bus.SYS_LB_LEN);
      wp_cnt = 0;
      wp_active = 1'b1;
    end
    for (int n = 0; n < 4; n++) begin
      if (bus.UP_ACK[n]) begin
        ack_cnt[n]++;
        up_ack_cyc[n] = cyc;
        outstanding = 0;
        if (!hold_req[n]) drop_pend[n] = 1'b1;
      end
    end
    bus.SYS_LB_ACK  = inj_ack;
    inj_ack         = 1'b0;
    bus.SYS_LB_RDEN = force_rden;
    if (wp_active) begin
      if (wp_cnt == wp_len) begin
        bus.SYS_LB_ACK = 1'b1;
        wp_active  = 1'b0;
        wp_ack_cyc = cyc;
      end else if (bus.SYS_LB_RRDY) begin
        bus.SYS_LB_RDEN = 1'b1;
        wp_cnt++;
      end
    end
    #1;
    for (int n = 0; n < 4; n++) begin
      if (bus.UP_RDEN[n]) begin
        rden_cnt[n]++;
        if (bus.SYS_LB_RDAT !== pat(n)) rdat_bad++;
      end
    end
  endtask

  task automatic do_reset();
    RST = 1'b1;
    bus.UP_REQ = '0;
    wp_active = 1'b0;
    drop_pend = '0;
    hold_req  = '0;
    cycle();
    cycle();
    RST = 1'b0;
    clr();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.UP_REQ = '0; bus.UP_ADR = '0; bus.UP_LEN = '0;
    bus.UP_RRDY = '1; bus.UP_RDAT = '0;
    bus.SYS_LB_ACK = 1'b0; bus.SYS_LB_RDEN = 1'b0;
    inj_ack = 1'b0; force_rden = 1'b0; wp_active = 1'b0;
    drop_pend = '0; hold_req = '0;
    for (int n = 0; n < 4; n++) bus.UP_RDAT[256*n +: 256] = pat(n);
    clr();

    // Reset values
    cycle();
    cycle();
    chk("rst_req",  bus.SYS_LB_REQ, 0);
    chk("rst_adr",  bus.SYS_LB_ADR, 0);
    chk("rst_len",  bus.SYS_LB_LEN, 0);
    chk("rst_ack",  bus.UP_ACK, 0);
    chk("rst_busy", bus.BUSY, 0);
    chk("rst_gnt",  bus.GNT_IDX, 0);
    RST = 1'b0;
    cycle();

    // 1: single request on port 2, 256 words
    clr();
    set_port(2, 32'h1000, 20'd256);
    bus.UP_REQ[2] = 1'b1;
    cycle();
    chk("t1_req_c1",  bus.SYS_LB_REQ, 0);
    chk("t1_busy_c1", bus.BUSY, 0);
    cycle();
    chk("t1_req_c2",  bus.SYS_LB_REQ, 1);
    chk("t1_adr",     bus.SYS_LB_ADR, 32'h1000);
    chk("t1_len",     bus.SYS_LB_LEN, 256);
    chk("t1_gnt",     bus.GNT_IDX, 2);
    chk("t1_busy_c2", bus.BUSY, 1);
    cycle();
    chk("t1_req_c3",  bus.SYS_LB_REQ, 0);
    for (int t = 0; t < 400 && ack_cnt[2] == 0; t++) cycle();
    chk("t1_ack_cnt",  ack_cnt[2], 1);
    chk("t1_ack_lat",  up_ack_cyc[2] - wp_ack_cyc, 1);
    chk("t1_rden2",    rden_cnt[2], 256);
    chk("t1_rden_oth", rden_cnt[0] + rden_cnt[1] + rden_cnt[3], 0);
    chk("t1_rdat_bad", rdat_bad, 0);
    cycle();
    chk("t1_ack_1cyc", bus.UP_ACK, 0);
    chk("t1_adr_hold", bus.SYS_LB_ADR, 32'h1000);
    chk("t1_len_hold", bus.SYS_LB_LEN, 256);
    for (int t = 0; t < 6; t++) cycle();
    chk("t1_req_once", req_pulses, 1);

    // 2: all four ports at once, LEN=4
    do_reset();
    for (int n = 0; n < 4; n++) set_port(n, 32'h2000 + 32'(n) * 32'h100, 20'd4);
    bus.UP_REQ = 4'b1111;
    for (int t = 0; t < 200 && (ack_cnt[0] + ack_cnt[1] + ack_cnt[2] + ack_cnt[3]) < 4; t++) cycle();
    chk("t2_ngrants", gnt_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t2_order%0d", i), gnt_log[i], i);
      chk($sformatf("t2_adr%0d", i), adr_log[i], 32'h2000 + 32'(i) * 32'h100);
      chk($sformatf("t2_rden%0d", i), rden_cnt[i], 4);
    end
    chk("t2_overlap", overlap, 0);
    chk("t2_rdat_bad", rdat_bad, 0);

    // 3: zero-length request on port 1 completes locally
    do_reset();
    set_port(1, 32'h3300, 20'd0);
    bus.UP_REQ[1] = 1'b1;
    cycle();
    chk("t3_ack_c1", bus.UP_ACK, 0);
    cycle();
    chk("t3_ack_c2",  bus.UP_ACK, 4'b0010);
    chk("t3_busy_c2", bus.BUSY, 1);
    chk("t3_gnt",     bus.GNT_IDX, 1);
    cycle();
    chk("t3_ack_c3", bus.UP_ACK, 0);
    for (int t = 0; t < 6; t++) cycle();
    chk("t3_no_req", req_pulses, 0);
    chk("t3_ack_cnt", ack_cnt[1], 1);

    // 4: spurious ACK in IDLE, port 3 drops REQ mid-WAIT
    do_reset();
    inj_ack = 1'b1;
    for (int t = 0; t < 3; t++) cycle();
    chk("t4_spur_ack", ack_cnt[0] + ack_cnt[1] + ack_cnt[2] + ack_cnt[3], 0);
    set_port(3, 32'h3000, 20'd8);
    bus.UP_REQ[3] = 1'b1;
    for (int t = 0; t < 10 && req_pulses == 0; t++) cycle();
    cycle();
    cycle();
    bus.UP_REQ[3] = 1'b0;
    for (int t = 0; t < 50 && ack_cnt[3] == 0; t++) cycle();
    chk("t4_ack3",  ack_cnt[3], 1);
    chk("t4_rden3", rden_cnt[3], 8);
    chk("t4_acks",  ack_cnt[0] + ack_cnt[1] + ack_cnt[2] + ack_cnt[3], 1);

    // 5: reset mid-transfer; pointer returns to port 0
    do_reset();
    set_port(0, 32'h0, 20'd0);
    bus.UP_REQ[0] = 1'b1;
    for (int t = 0; t < 10 && ack_cnt[0] == 0; t++) cycle();
    cycle();
    set_port(1, 32'h5000, 20'd256);
    bus.UP_REQ[1] = 1'b1;
    for (int t = 0; t < 300 && rden_cnt[1] < 100; t++) cycle();
    chk("t5_words", rden_cnt[1], 100);
    RST = 1'b1;
    wp_active  = 1'b0;
    force_rden = 1'b1;
    cycle();
    chk("t5_req",  bus.SYS_LB_REQ, 0);
    chk("t5_ack",  bus.UP_ACK, 0);
    chk("t5_rden", bus.UP_RDEN, 0);
    chk("t5_busy", bus.BUSY, 0);
    chk("t5_gnt",  bus.GNT_IDX, 0);
    chk("t5_len",  bus.SYS_LB_LEN, 0);
    RST = 1'b0;
    force_rden = 1'b0;
    clr();
    set_port(0, 32'h0500, 20'd4);
    bus.UP_REQ[0] = 1'b1;
    for (int t = 0; t < 10 && req_pulses == 0; t++) cycle();
    chk("t5_next_gnt", (gnt_log.size() > 0) ? gnt_log[0] : 99, 0);
    for (int t = 0; t < 400 && ack_cnt[1] == 0; t++) cycle();
    chk("t5_p1_done", ack_cnt[1], 1);

    // 6: ports 0 and 2 request continuously
    do_reset();
`ifdef MEM_WR_ARB_PRIO_EN
    exp6 = '{0, 0, 0, 0};
`else
    exp6 = '{0, 2, 0, 2};
`endif
    hold_req = 4'b0101;
    set_port(0, 32'h6000, 20'd2);
    set_port(2, 32'h6200, 20'd2);
    bus.UP_REQ = 4'b0101;
    for (int t = 0; t < 100 && req_pulses < 4; t++) cycle();
    chk("t6_ngrants", gnt_log.size() >= 4, 1);
    for (int i = 0; i < 4; i++) chk($sformatf("t6_order%0d", i), gnt_log[i], exp6[i]);
    chk("t6_overlap", overlap, 0);
    hold_req = '0;
    bus.UP_REQ = '0;
    for (int t = 0; t < 20; t++) cycle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
